fsm_spit_dac: RTL
=================

Name: fsm_spit_dac

Overview:
- SPI transmitter (master, mode 0) that serializes one command/data word to the DAC/ADC configuration input.
- Write-direction counterpart of the ADC conversion-capture receiver.
- Generates its own SCLK from the system clock, drives CS and MOSI, and reports end-of-transfer with a level (eot_o) and a pulse (done_o).
- Sits between the system control FSM (which issues strt_i with a word) and the converter pins.

Parameters:
- DATA_W, 24, number of bits per frame, sent MSB first; legal range 2..32.
- DIV, 2, SCLK half-period in clk_i cycles; legal range 1..255.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- strt_i  input  1  start request; sampled only in IDLE.
- data_i  input  DATA_W  word to send; captured in the same cycle strt_i is accepted.
- sclk_o  output  1  SPI clock; idles low.
- mosi_o  output  1  serial data out.
- cs_o  output  1  chip select, active-low.
- eot_o  output  1  high when idle and able to accept strt_i; low during a frame.
- done_o  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, cs_o=1, sclk_o=0, mosi_o=0, eot_o=1, done_o=0, shift register, phase counter and bit counter all cleared.
- Reset asserted mid-frame aborts the frame immediately: cs_o rises without waiting for a clock edge, and no done_o is issued.
- States: IDLE, SETUP, HIGH, LOW, DONE. All outputs are registered (no combinational paths from inputs to pins).
- IDLE: cs_o=1, sclk_o=0, eot_o=1.
  - strt_i=1 at a rising edge: load data_i into the shift register, clear counters, go to SETUP.
  - strt_i=0: stay in IDLE; data_i is ignored.
- SETUP (DIV cycles): cs_o=0, sclk_o=0, mosi_o=data[DATA_W-1], eot_o=0. Then go to HIGH.
- HIGH (DIV cycles): sclk_o=1, mosi_o stable. On exit, the bit counter increments, then go to LOW.
- LOW (DIV cycles): sclk_o=0.
  - Entering LOW with bits remaining: shift left by one in the same cycle sclk_o falls, so mosi_o presents the next bit.
  - After LOW with bit counter < DATA_W: go to HIGH.
  - Last LOW (bit counter == DATA_W): no shift; mosi_o holds the LSB. This phase acts as the CS hold time. Then go to DONE.
- DONE (1 cycle): cs_o=1, sclk_o=0, mosi_o=0, done_o=1, eot_o=1. strt_i is ignored in this cycle. Next state is IDLE.
- Timing, with the strt_i accept edge at cycle 0:
  - cs_o low from cycle 1 through cycle DIV*(2*DATA_W+1), inclusive.
  - done_o high in cycle DIV*(2*DATA_W+1)+1.
  - Earliest next accept is the following cycle.
  - Exactly DATA_W rising edges of sclk_o per frame; mosi_o is stable DIV cycles before and after each rising edge.
- strt_i while busy (SETUP/HIGH/LOW) has no effect. data_i changes after capture do not affect the frame in progress.
- The phase counter is sized ceil(log2(DIV+1)) bits and reloads at every phase change; it never wraps.
- The bit counter is sized ceil(log2(DATA_W+1)) bits.

Test Plan:
1. Reset values: DIV=2, DATA_W=24. Hold rst_i=0 for 3 cycles, then release -> cs_o=1, sclk_o=0, mosi_o=0, eot_o=1, done_o=0.
2. Single frame: data_i=24'hA5C3F0, strt_i pulsed at cycle 0.
   - cs_o low cycles 1..98; done_o=1 in cycle 99 only.
   - 24 sclk_o rising edges, the first at cycle 3.
   - A receiver model sampling mosi_o on rising sclk_o reconstructs 24'hA5C3F0.
3. Busy rejection and data stability: during the frame of test 2, pulse strt_i at cycles 10 and 98 and change data_i to 24'h000000 -> only one frame occurs, bits are unchanged, and exactly one done_o pulse is seen.
4. Back-to-back frames: hold strt_i=1 continuously with data_i=24'hFFFFFF, then 24'h000001.
   - The second frame's cs_o falls at cycle 101 (accept edge at 100); cs_o is high for 2 cycles between frames.
   - Decoded words are 24'hFFFFFF then 24'h000001.
5. Reset mid-frame: assert rst_i=0 asynchronously at cycle 40 -> cs_o=1 and sclk_o=0 before the next clk_i edge, no done_o. A new strt_i after release produces a correct full frame.
6. Minimum divider: DIV=1, DATA_W=8, data_i=8'h3C -> sclk_o period 2 cycles, cs_o low cycles 1..17, done_o at cycle 18, decoded word 8'h3C.

Source files
------------

// File: rtl/fsm_spit_dac.sv
// fsm_spit_dac: SPI mode-0 master that shifts one DATA_W-bit word out MSB first.
// Every pin is registered from the next-state decode, so there is no input-to-pin path.
module fsm_spit_dac #(
    parameter int DATA_W = 24,
    parameter int DIV    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              strt_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_o,
    output logic              eot_o,
    output logic              done_o
);
    localparam int PW = $clog2(DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

    state_t            state, n_state;
    logic [PW-1:0]     cnt, n_cnt;
    logic [BW-1:0]     bcnt, n_bcnt;
    logic [DATA_W-1:0] sh, n_sh;
    logic              last, act;

    assign last = cnt == PW'(DIV - 1);
    assign act  = n_state inside {SETUP, HIGH, LOW};

    always_comb begin
        n_state = state;
        n_cnt   = cnt + 1'b1;
        n_bcnt  = bcnt;
        n_sh    = sh;
        case (state)
            IDLE: begin
                n_cnt = '0;
                if (strt_i) begin
                    n_state = SETUP;
                    n_sh    = data_i;
                    n_bcnt  = '0;
                end
            end
            SETUP: if (last) begin
                n_state = HIGH;
                n_cnt   = '0;
            end
            // The shift lands on the falling SCLK edge; the final bit is held through the CS hold phase.
            HIGH: if (last) begin
                n_state = LOW;
                n_cnt   = '0;
                n_bcnt  = bcnt + 1'b1;
                if (bcnt != BW'(DATA_W - 1)) n_sh = {sh[DATA_W-2:0], 1'b0};
            end
            LOW: if (last) begin
                n_state = (bcnt == BW'(DATA_W)) ? DONE : HIGH;
                n_cnt   = '0;
            end
            DONE: begin
                n_state = IDLE;
                n_cnt   = '0;
            end
            default: begin
                n_state = IDLE;
                n_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            bcnt   <= '0;
            sh     <= '0;
            sclk_o <= 1'b0;
            mosi_o <= 1'b0;
            cs_o   <= 1'b1;
            eot_o  <= 1'b1;
            done_o <= 1'b0;
        end else begin
            state  <= n_state;
            cnt    <= n_cnt;
            bcnt   <= n_bcnt;
            sh     <= n_sh;
            sclk_o <= n_state == HIGH;
            mosi_o <= act & n_sh[DATA_W-1];
            cs_o   <= !act;
            eot_o  <= !act;
            done_o <= n_state == DONE;
        end
    end
endmodule
